vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  H_VISIBLE, 640, active pixels per line
  H_FP, 16, horizontal front porch in pixels
  H_SYNC, 96, horizontal sync width in pixels
  H_BP, 48, horizontal back porch in pixels
  V_VISIBLE, 480, active lines per frame
  V_FP, 10, vertical front porch in lines
  V_SYNC, 2, vertical sync width in lines
  V_BP, 33, vertical back porch in lines
  BLANK_DELAY, 1, pipeline stages applied to blank
  SYNC_DELAY, 2, pipeline stages applied to hs_n, vs_n and frame_start
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  vga_clk  in  1  pixel clock; the only clock
  reset_n  in  1  asynchronous, active-low reset
  DrawX  out  10  current pixel column
  DrawY  out  10  current pixel row
  blank  out  1  1 = active video (display enable), delayed by BLANK_DELAY
  hs_n  out  1  horizontal sync, active low, delayed by SYNC_DELAY
  vs_n  out  1  vertical sync, active low, delayed by SYNC_DELAY
  frame_start  out  1  one-cycle pulse at the first pixel of each frame, delayed by SYNC_DELAY
REQ-003 The design SHALL use one clock, vga_clk; reset_n SHALL be asynchronous and active-low.

Function
REQ-004 H_TOTAL SHALL equal H_VISIBLE+H_FP+H_SYNC+H_BP (default 800), and V_TOTAL SHALL equal V_VISIBLE+V_FP+V_SYNC+V_BP (default 525).
REQ-005 The horizontal counter hc SHALL increment every vga_clk cycle and SHALL wrap from H_TOTAL-1 to 0.
REQ-006 The vertical counter vc SHALL increment only on the cycle in which hc wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-007 DrawX SHALL equal hc and DrawY SHALL equal vc; both SHALL be registered outputs with zero added delay.
REQ-008 Raw active SHALL be 1 iff hc < H_VISIBLE and vc < V_VISIBLE; blank SHALL be raw active delayed by exactly BLANK_DELAY cycles.
REQ-009 Raw hs_n SHALL be 0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (default 656..751).
REQ-010 Raw vs_n SHALL be 0 for whole lines iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (default 490..491).
REQ-011 Raw frame_start SHALL be 1 iff hc==0 and vc==0, excluding the first (0,0) after reset release, so that exactly one pulse occurs per completed wrap.
REQ-012 hs_n, vs_n and frame_start SHALL each be delayed by exactly SYNC_DELAY cycles through matched stages, so that their mutual alignment is preserved.
REQ-013 A delay parameter of 0 SHALL pass the raw signal through combinationally from the registered counters.
REQ-014 All arithmetic SHALL be unsigned; counters SHALL be 10 bits, and no value >= H_TOTAL or V_TOTAL SHALL appear on DrawX or DrawY.

Reset
REQ-015 While reset_n is 0, outputs SHALL immediately take these values: DrawX=0, DrawY=0, blank=0, hs_n=1, vs_n=1, frame_start=0.
REQ-016 Reset SHALL clear all delay stages to their inactive values: blank 0, syncs 1, frame_start 0.
REQ-017 On the first rising edge after reset_n rises, hc SHALL become 1; reset asserted mid-frame SHALL abandon the frame with no partial pulses afterwards.

Structure
REQ-018 The default timing constants and the derived H_TOTAL and V_TOTAL SHALL live in the shared package vga_pkg.
REQ-019 The delay stages SHALL be implemented by one parameterised sub-module, vga_delay (parameters: width, depth, reset value), instantiated for blank and for {hs_n, vs_n, frame_start}.

Verification
REQ-020 Line wrap: run to DrawX=799, DrawY=10 -> next cycle DrawX=0, DrawY=11.
REQ-021 Frame wrap: DrawX=799, DrawY=524 -> next cycle (0,0); frame_start high for exactly 1 cycle, 2 cycles later; period 420000 cycles.
REQ-022 hs_n: low for exactly 96 consecutive cycles per line, first low cycle 2 cycles after DrawX=656.
REQ-023 vs_n: low for exactly 1600 cycles per frame, starting 2 cycles after (DrawX=0, DrawY=490).
REQ-024 blank: high exactly 640 cycles per visible line, falling 1 cycle after DrawX=640; constantly 0 for DrawY 480..524.
REQ-025 Reset mid-frame: drop reset_n at (300,200) between clock edges -> outputs equal the REQ-015 values immediately; after release DrawX=1,2,3…; no frame_start until first wrap.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants (640x480 @ 60 Hz defaults) and the
// derived line/frame totals, plus the counter width used by the generator.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525

  // Half-open range test lo <= v < hi on counter-width values.
  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_delay.sv
// vga_delay: DEPTH-stage register pipeline for a WIDTH-bit bundle. Every
// stage resets to RST_VAL, so a reset flushes any in-flight pulse.
// DEPTH = 0 is a combinational pass-through that still presents RST_VAL
// while reset is asserted.
//   clk   in  clock
//   rst_n in  async active-low reset
//   d     in  [WIDTH-1:0] raw value
//   q     out [WIDTH-1:0] value delayed by DEPTH cycles
module vga_delay #(
  parameter int                 WIDTH   = 1,
  parameter int                 DEPTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = rst_n ? d : RST_VAL;
    end else begin : g_pipe
      logic [DEPTH-1:0][WIDTH-1:0] stg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg <= {DEPTH{RST_VAL}};
        end else begin
          stg[0] <= d;
          for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
      end

      assign q = stg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing. A free-running pixel counter (hc) and
// line counter (vc) drive DrawX/DrawY directly; blank, the syncs and the
// frame_start pulse are decoded from the counters and then delayed so that
// they line up with a downstream pixel pipeline.
//   vga_clk     in   pixel clock
//   reset_n     in   async active-low reset
//   DrawX       out  [9:0] current column (hc)
//   DrawY       out  [9:0] current row (vc)
//   blank       out  1 = active video, delayed BLANK_DELAY
//   hs_n        out  hsync, active low, delayed SYNC_DELAY
//   vs_n        out  vsync, active low, delayed SYNC_DELAY
//   frame_start out  one-cycle pulse at (0,0) of each new frame, delayed SYNC_DELAY
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE   = DEF_H_VISIBLE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_VISIBLE   = DEF_V_VISIBLE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int BLANK_DELAY = 1,
  parameter int SYNC_DELAY  = 2
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             blank,
  output logic             hs_n,
  output logic             vs_n,
  output logic             frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hc, vc;
  // Low only until the first edge after reset: masks the (0,0) that reset
  // itself creates, so frame_start marks completed wraps only.
  logic             started;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc      <= '0;
      vc      <= '0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + CNT_W'(1);
      end else begin
        hc <= hc + CNT_W'(1);
      end
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;

  logic act_raw, hs_raw, vs_raw, fs_raw;

  assign act_raw = (hc < H_ACT) && (vc < V_ACT);
  assign hs_raw  = ~in_range(hc, HS_BEG, HS_END);
  assign vs_raw  = ~in_range(vc, VS_BEG, VS_END);
  assign fs_raw  = started && (hc == '0) && (vc == '0);

  vga_delay #(
    .WIDTH   (1),
    .DEPTH   (BLANK_DELAY),
    .RST_VAL (1'b0)
  ) u_blank_dly (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .d     (act_raw),
    .q     (blank)
  );

  // Syncs and frame_start share one pipeline so they stay mutually aligned.
  logic [2:0] sync_q;

  vga_delay #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (3'b110)
  ) u_sync_dly (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .d     ({hs_raw, vs_raw, fs_raw}),
    .q     (sync_q)
  );

  assign {hs_n, vs_n, frame_start} = sync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Horizontal timing stays at the 800-pixel
// default; the frame is shortened to 19 lines (12 visible, FP 2, sync 2,
// BP 3) so whole frames fit in a short run. Expected values are worked out
// by hand from those constants and the 1/2-cycle output delays.
module tb_vga_timing_gen;

  localparam int HT    = 800;
  localparam int VT    = 19;
  localparam int FRAME = HT * VT;   // 15200

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] DrawX, DrawY;
  logic       blank, hs_n, vs_n, frame_start;

  vga_timing_gen #(
    .V_VISIBLE (12),
    .V_FP      (2),
    .V_SYNC    (2),
    .V_BP      (3)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .hs_n        (hs_n),
    .vs_n        (vs_n),
    .frame_start (frame_start)
  );

  always #5 vga_clk = ~vga_clk;

  int vectors = 0;
  int errs    = 0;
  int fs_cnt  = 0;
  int oob     = 0;

  // Values seen here are those of the cycle that this edge closes.
  always @(posedge vga_clk) begin
    if (reset_n === 1'b1) begin
      if (frame_start === 1'b1) fs_cnt++;
      if (DrawX >= HT || DrawY >= VT) oob++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    @(negedge vga_clk);
  endtask

  task automatic run_to(input int x, input int y, input int budget);
    int n = 0;
    while (!(DrawX == x && DrawY == y) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      chk("run_to_x", DrawX, x);
      chk("run_to_y", DrawY, y);
    end
  endtask

  task automatic chk_reset_vals(input string sfx);
    chk({"rst_x", sfx},  DrawX, 0);
    chk({"rst_y", sfx},  DrawY, 0);
    chk({"rst_blank", sfx}, blank, 0);
    chk({"rst_hs", sfx}, hs_n, 1);
    chk({"rst_vs", sfx}, vs_n, 1);
    chk({"rst_fs", sfx}, frame_start, 0);
  endtask

  initial begin
    int n;
    int fs_base;

    // Power-up reset
    #3 reset_n = 1'b0;
    #1 chk_reset_vals("_async");
    repeat (3) @(negedge vga_clk);
    chk_reset_vals("_held");

    // Release between edges; counting restarts at 1
    reset_n = 1'b1;
    fs_base = fs_cnt;
    step();
    chk("start_x1", DrawX, 1);
    chk("start_y", DrawY, 0);
    chk("start_blank", blank, 1);   // raw active at (0,0)
    chk("start_hs", hs_n, 1);
    step(); chk("start_x2", DrawX, 2);
    step(); chk("start_x3", DrawX, 3);

    // Line wrap
    run_to(799, 10, 20000);
    step();
    chk("lwrap_x", DrawX, 0);
    chk("lwrap_y", DrawY, 11);

    // Visible line: 640 active cycles, falling one cycle after DrawX=640
    n = 0;
    for (int i = 0; i < HT; i++) begin
      if (blank) n++;
      if (DrawX == 640) chk("blank_at640", blank, 1);
      if (DrawX == 641) chk("blank_at641", blank, 0);
      if (i < HT - 1) step();
    end
    chk("blank_cnt", n, 640);

    // Vertical blanking rows 12..18: never active
    step();
    n = 0;
    for (int i = 0; i < 7 * HT; i++) begin
      if (blank) n++;
      if (i < 7 * HT - 1) step();
    end
    chk("vblank_cnt", n, 0);
    chk("vblank_end_y", DrawY, 18);

    // Frame wrap: no pulse in the first frame, then pulse 2 cycles after (0,0)
    chk("fs_first_frame", fs_cnt - fs_base, 0);
    step();
    chk("fwrap_x", DrawX, 0);
    chk("fwrap_y", DrawY, 0);
    chk("fs_at0", frame_start, 0);
    step(); chk("fs_at1", frame_start, 0);
    step(); chk("fs_at2", frame_start, 1);
    step(); chk("fs_width", frame_start, 0);
    n = 1;
    while (frame_start !== 1'b1 && n < FRAME + 100) begin
      step();
      n++;
    end
    chk("fs_period", n, FRAME);

    // hsync: first low 2 cycles after DrawX=656, 96 cycles long
    run_to(656, 0, 2000);
    chk("hs_at656", hs_n, 1);
    step(); chk("hs_at657", hs_n, 1);
    step(); chk("hs_at658", hs_n, 0);
    n = 0;
    while (hs_n === 1'b0 && n < 1000) begin
      n++;
      step();
    end
    chk("hs_width", n, 96);

    // vsync: first low 2 cycles after (0,14), 2 lines = 1600 cycles
    run_to(0, 14, FRAME + 10);
    chk("vs_at0", vs_n, 1);
    step(); chk("vs_at1", vs_n, 1);
    step(); chk("vs_at2", vs_n, 0);
    n = 0;
    while (vs_n === 1'b0 && n < 5000) begin
      n++;
      step();
    end
    chk("vs_width", n, 1600);

    // Reset mid-frame between edges
    run_to(300, 5, FRAME + 10);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("_mid");
    @(negedge vga_clk);
    @(negedge vga_clk);
    chk_reset_vals("_mid_held");
    reset_n = 1'b1;
    fs_base = fs_cnt;
    step(); chk("rst2_x1", DrawX, 1);
    chk("rst2_y", DrawY, 0);
    step(); chk("rst2_x2", DrawX, 2);
    chk("rst2_fs", frame_start, 0);
    step(); chk("rst2_x3", DrawX, 3);
    run_to(799, 18, FRAME + 10);
    chk("rst2_no_fs", fs_cnt - fs_base, 0);
    step(); step(); step();
    chk("rst2_fs_wrap", frame_start, 1);

    chk("coord_range", oob, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
